// File: rtl/uart_pkg.sv
// Shared UART constants and helpers for the receiver, transmitter and their FIFOs.
package uart_pkg;

    localparam int UART_DATA_WIDTH        = 8;
    localparam int UART_RX_FIFO_DEPTH     = 16;
    localparam int UART_RX_FIFO_IRQ_LEVEL = 8;

    // Occupancy counters need one extra bit so a completely full FIFO is representable.
    function automatic int fifo_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-push / valid-ready-pop / status bundle between the UART receive FIFO and its environment.
// The irq signal is present only when UART_RX_FIFO_IRQ_EN is defined.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);
    logic                          rx_done;
    logic [DATA_WIDTH-1:0]         rx_data;
    logic                          rd_valid;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          rd_ready;
    logic [fifo_level_w(DEPTH)-1:0] level;
    logic                          full;
    logic                          overrun;
    logic                          overrun_clr;
`ifdef UART_RX_FIFO_IRQ_EN
    logic                          irq;

    modport master (
        output rx_done, rx_data, rd_ready, overrun_clr,
        input  rd_valid, rd_data, level, full, overrun, irq
    );
    modport slave (
        input  rx_done, rx_data, rd_ready, overrun_clr,
        output rd_valid, rd_data, level, full, overrun, irq
    );
`else
    modport master (
        output rx_done, rx_data, rd_ready, overrun_clr,
        input  rd_valid, rd_data, level, full, overrun
    );
    modport slave (
        input  rx_done, rx_data, rd_ready, overrun_clr,
        output rd_valid, rd_data, level, full, overrun
    );
`endif
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one combinational read port.
// Shared by the receive and transmit FIFOs.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the level counter,
    // so a reset here would only cost area and block mapping onto RAM/LUT-RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with level/full/sticky overrun.
// Define UART_RX_FIFO_IRQ_EN to add a registered fill-level/overrun interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    parameter int IRQ_LEVEL  = UART_RX_FIFO_IRQ_LEVEL
`endif
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = fifo_level_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             overrun_q, overrun_d;

    logic             empty;
    logic             is_full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [DATA_WIDTH-1:0] head_data;

    assign empty   = (level_q == '0);
    assign is_full = (level_q == LVL_W'(DEPTH));

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts that byte.
    assign pop  = !empty && bus.rd_ready;
    assign push = bus.rx_done && (!is_full || pop);
    assign drop = bus.rx_done && is_full && !pop;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Set has priority so a byte lost in the clearing cycle is never hidden.
        if (bus.overrun_clr) overrun_d = 1'b0;
        if (drop)            overrun_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.rx_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    assign bus.rd_valid = !empty;
    assign bus.rd_data  = head_data;
    assign bus.level    = level_q;
    assign bus.full     = is_full;
    assign bus.overrun  = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (level_q >= LVL_W'(IRQ_LEVEL)) || overrun_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus random traffic against a queue model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = UART_RX_FIFO_DEPTH;
    localparam int DW    = UART_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model_q[$];
    logic          m_ovr = 1'b0;
    logic          m_irq = 1'b0;
    logic [DW-1:0] last_pop;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".level"},    32'(bus.level),    32'(model_q.size()));
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(model_q.size() != 0));
        check({tag, ".full"},     32'(bus.full),     32'(model_q.size() == DEPTH));
        check({tag, ".overrun"},  32'(bus.overrun),  32'(m_ovr));
        if (model_q.size() != 0) check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(model_q[0]));
`ifdef UART_RX_FIFO_IRQ_EN
        check({tag, ".irq"}, 32'(bus.irq), 32'(m_irq));
`endif
    endtask

    // One clock: apply inputs, advance the model from pre-edge state, sample #1 after the edge.
    task automatic cycle(input logic done, input logic [DW-1:0] data,
                         input logic rdy, input logic clr);
        bit do_pop, do_push, do_drop;
        bus.rx_done     = done;
        bus.rx_data     = data;
        bus.rd_ready    = rdy;
        bus.overrun_clr = clr;
        do_pop  = rdy && (model_q.size() != 0);
        do_push = done && ((model_q.size() < DEPTH) || do_pop);
        do_drop = done && !do_push;
        m_irq   = (model_q.size() >= UART_RX_FIFO_IRQ_LEVEL) || m_ovr;
        if (do_pop) begin
            check("pop_data", 32'(bus.rd_data), 32'(model_q[0]));
            last_pop = model_q.pop_front();
        end
        if (do_push) model_q.push_back(data);
        if (do_drop)  m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        bus.rx_done     = 1'b0;
        bus.rd_ready    = 1'b0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic drain();
        while (model_q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.rx_done     = 1'b0;
        bus.rx_data     = '0;
        bus.rd_ready    = 1'b0;
        bus.overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("reset");

        // Three pushes then in-order drain.
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        check_state("push1_latency");
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        check("three.level", 32'(bus.level), 32'd3);
        check("three.head",  32'(bus.rd_data), 32'h41);
        check_state("three");
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("drain3.last", 32'(last_pop), 32'h43);
        check_state("drain3");
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("pop_empty_ignored");

        // Fill to full, drop one, drain.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill.full", 32'(bus.full), 32'd1);
        check_state("fill");
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("drop.overrun", 32'(bus.overrun), 32'd1);
        check_state("drop");
        drain();
        check("drain16.last", 32'(last_pop), 32'h0F);
        check_state("drain16");
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_state("ovr_clear");

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check("full_pp.level", 32'(bus.level), 32'd16);
        check_state("full_pp");
        drain();
        check("full_pp.last", 32'(last_pop), 32'h55);

        // Empty with simultaneous push and pop.
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        check_state("empty_pp");
        drain();

        // Random traffic across pointer wraps.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
            if (i % 3 == 0) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
            check("wrap.level_bound", 32'(bus.level <= DEPTH), 32'd1);
            check_state("wrap");
        end
        drain();
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_state("wrap_done");

        // Overrun clear collides with a new drop: set wins.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        check_state("ovr_set");
        cycle(1'b1, 8'h02, 1'b0, 1'b1);
        check("ovr_collide", 32'(bus.overrun), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("ovr_clr_alone", 32'(bus.overrun), 32'd0);
        check_state("ovr_clr");
        drain();

        // Fill-level interrupt threshold.
        for (int i = 0; i < UART_RX_FIFO_IRQ_LEVEL; i++) begin
            cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
            check_state("irq_fill");
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_state("irq_on");
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("irq_pop");
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_state("irq_off");
        drain();
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with five bytes stored and overrun set.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst.level", 32'(bus.level), 32'd5);
        check_state("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        m_ovr = 1'b0;
        m_irq = 1'b0;
        check("rst.level",    32'(bus.level),    32'd0);
        check("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst.overrun",  32'(bus.overrun),  32'd0);
        check_state("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        check_state("post_rst_push");
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_state("post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
